ddr_mem_responder: RTL

DDR_MEM_RESPONDER -- requirements
Module: ddr_mem_responder

---
 rtl/ddr_mem_responder.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ddr_mem_responder.sv
// Behavioural DDR-style memory responder: one transaction in flight, single-word writes,
// fixed-latency incrementing read bursts out of a simple dual-port block RAM.
module ddr_mem_responder #(
    parameter int DEPTH_WORDS  = 4096,
    parameter int READ_LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ddr_read_req,
    input  logic [31:0] ddr_read_addr,
    input  logic [7:0]  ddr_read_len,
    output logic        ddr_read_grant,
    output logic [31:0] ddr_read_data,
    output logic        ddr_read_valid,
    input  logic        ddr_write_req,
    input  logic [31:0] ddr_write_addr,
    input  logic [31:0] ddr_write_data,
    output logic        ddr_write_grant,
    input  logic        init_we,
    input  logic [31:0] init_addr,
    input  logic [31:0] init_data,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WR_ACK, RD_WAIT, RD_BURST} state_t;

    state_t          state;
    state_t          state_nxt;
    logic            rr_wr_pri;
    logic [3:0]      wait_cnt;
    logic [8:0]      beat_cnt;
    logic [AW-1:0]   rd_ptr;
    logic [7:0]      len_q;
    logic [31:0]     rd_word_p1;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            take_rd;
    logic            take_wr;
    logic            wait_done;
    logic            last_beat;
    logic            rd_adv;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [31:0]     mem_wdata;
    logic            unused_addr_bits;

    assign unused_addr_bits = ^{ddr_read_addr[31:AW+2], ddr_read_addr[1:0],
                                ddr_write_addr[31:AW+2], ddr_write_addr[1:0],
                                init_addr[31:AW]};

    // Arbitration: backdoor preload blocks acceptance; conflicts resolved by rr_wr_pri.
    always_comb begin
        take_rd   = 1'b0;
        take_wr   = 1'b0;
        state_nxt = state;
        wait_done = (wait_cnt == 4'(READ_LATENCY - 1));
        last_beat = (beat_cnt == {1'b0, len_q});
        rd_adv    = 1'b0;
        unique case (state)
            IDLE: begin
                take_rd = !init_we && ddr_read_req  && (!ddr_write_req || !rr_wr_pri);
                take_wr = !init_we && ddr_write_req && (!ddr_read_req  ||  rr_wr_pri);
                if (take_rd)      state_nxt = RD_WAIT;
                else if (take_wr) state_nxt = WR_ACK;
            end
            WR_ACK: state_nxt = IDLE;
            RD_WAIT: begin
                rd_adv = wait_done;
                if (wait_done) state_nxt = RD_BURST;
            end
            RD_BURST: begin
                rd_adv = !last_beat;
                if (last_beat) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_we    = init_we || take_wr;
        mem_waddr = init_we ? init_addr[AW-1:0] : ddr_write_addr[AW+1:2];
        mem_wdata = init_we ? init_data : ddr_write_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_wr_pri <= 1'b0;
            wait_cnt  <= 4'd0;
            beat_cnt  <= 9'd0;
        end else begin
            state <= state_nxt;
            if ((take_rd || take_wr) && ddr_read_req && ddr_write_req)
                rr_wr_pri <= !rr_wr_pri;
            if (take_rd)
                wait_cnt <= 4'd0;
            else if (state == RD_WAIT)
                wait_cnt <= wait_cnt + 4'd1;
            if (state == RD_BURST)
                beat_cnt <= beat_cnt + 9'd1;
            else
                beat_cnt <= 9'd0;
        end
    end

    // rd_ptr always points at the word the RAM fetches on the coming edge.
    always_ff @(posedge clk) begin
        if (take_rd) begin
            rd_ptr <= ddr_read_addr[AW+1:2];
            len_q  <= ddr_read_len;
        end else if (rd_adv) begin
            rd_ptr <= rd_ptr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
        rd_word_p1 <= mem[rd_ptr];
    end

    assign ddr_read_grant  = (state == RD_WAIT) && (wait_cnt == 4'd0);
    assign ddr_read_valid  = (state == RD_BURST);
    assign ddr_read_data   = ddr_read_valid ? rd_word_p1 : 32'd0;
    assign ddr_write_grant = (state == WR_ACK);
    assign busy            = (state != IDLE);

endmodule
